// File: rtl/ros2_app_data_loader.sv
// CPU-side byte-stream loader for the ROS2 app-data register bank, arbitrated by a req/grant/rel handshake.
// Optional idle-timeout forced commit is enabled by defining ROS2_APP_DATA_LOADER_TIMEOUT_EN.
module ros2_app_data_loader #(
    parameter int MAX_LEN        = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic                 s_tlast,
    output logic                 app_data_cpu_req,
    output logic                 app_data_cpu_rel,
    input  logic                 app_data_cpu_grant,
    output logic [MAX_LEN*8-1:0] app_data,
    output logic [7:0]           app_data_len,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic                 timeout
);

    if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
        $error("MAX_LEN must be in 1..255");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 16-bit idle counter");
    end

    localparam logic [7:0] MAX_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, REQ, LOAD, REL, DRAIN} state_t;

    state_t     state;
    logic [7:0] idx;
    logic [7:0] mem [MAX_LEN];
    logic       accept;
    logic       idle_hit;

    // Byte count after one more accepted beat, pinned at capacity.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v < MAX_B) ? v + 8'd1 : MAX_B;
    endfunction

    assign s_tready = (state == LOAD) && app_data_cpu_grant;
    assign accept   = s_tready && s_tvalid;
    assign busy     = (state != IDLE);

    for (genvar i = 0; i < MAX_LEN; i++) begin : g_lane
        assign app_data[8*i +: 8] = mem[i];
    end

`ifdef ROS2_APP_DATA_LOADER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] idle_cnt;
    logic        timeout_q;

    // Only cycles with the grant held and no beat taken count as idle.
    assign idle_hit = (state == LOAD) && app_data_cpu_grant && !accept && (idle_cnt == TO_LAST);
    assign timeout  = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state != LOAD || accept)
                idle_cnt <= '0;
            else if (app_data_cpu_grant)
                idle_cnt <= idle_cnt + 16'd1;

            if (state == IDLE && s_tvalid)
                timeout_q <= 1'b0;
            else if (idle_hit)
                timeout_q <= 1'b1;
        end
    end
`else
    assign idle_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            idx              <= '0;
            app_data_len     <= '0;
            app_data_cpu_req <= 1'b0;
            app_data_cpu_rel <= 1'b0;
            done             <= 1'b0;
            overflow         <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++)
                mem[i] <= '0;
        end else begin
            app_data_cpu_rel <= 1'b0;
            done             <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_tvalid) begin
                        state            <= REQ;
                        app_data_cpu_req <= 1'b1;
                        idx              <= '0;
                        overflow         <= 1'b0;
                    end
                end
                REQ: begin
                    if (app_data_cpu_grant) begin
                        state            <= LOAD;
                        app_data_cpu_req <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        for (int i = 0; i < MAX_LEN; i++)
                            if (idx == 8'(i))
                                mem[i] <= s_tdata;
                        if (idx >= MAX_B)
                            overflow <= 1'b1;
                        idx <= sat_inc(idx);
                        if (s_tlast) begin
                            app_data_len     <= sat_inc(idx);
                            state            <= REL;
                            app_data_cpu_rel <= 1'b1;
                            done             <= 1'b1;
                        end
                    end else if (idle_hit) begin
                        // idx is already saturated, so it is the stored byte count.
                        app_data_len     <= idx;
                        state            <= REL;
                        app_data_cpu_rel <= 1'b1;
                        done             <= 1'b1;
                    end
                end
                REL:     state <= DRAIN;
                DRAIN:   if (!app_data_cpu_grant) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ros2_app_data_loader.sv
// Bench for ros2_app_data_loader: arbiter model, directed frames, random frames and a frame-level reference.
// Covers the optional ROS2_APP_DATA_LOADER_TIMEOUT_EN build in the idle-stall step.
module tb_ros2_app_data_loader;

    localparam int MAX_LEN = 4;
    localparam int TO_CYC  = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [7:0]           s_tdata = '0;
    logic                 s_tvalid = 1'b0;
    logic                 s_tlast = 1'b0;
    logic                 s_tready;
    logic                 req, rel, grant;
    logic [MAX_LEN*8-1:0] app_data;
    logic [7:0]           app_data_len;
    logic                 busy, done, overflow, timeout;

    ros2_app_data_loader #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .app_data_cpu_req(req), .app_data_cpu_rel(rel), .app_data_cpu_grant(grant),
        .app_data(app_data), .app_data_len(app_data_len),
        .busy(busy), .done(done), .overflow(overflow), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Arbiter: grants gnt_delay cycles after seeing req, withdraws the cycle after rel; ether_en masks it.
    int   gnt_delay = 0;
    int   wcnt;
    logic owned;
    logic ether_en = 1'b1;
    assign grant = owned & ether_en;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owned <= 1'b0;
            wcnt  <= 0;
        end else if (rel) begin
            owned <= 1'b0;
            wcnt  <= 0;
        end else if (req && !owned) begin
            if (wcnt >= gnt_delay) owned <= 1'b1;
            else wcnt <= wcnt + 1;
        end else if (!req) begin
            wcnt <= 0;
        end
    end

    int         total = 0;
    int         bad = 0;
    logic [7:0] fb [8];
    logic [7:0] nb [8];
    logic [7:0] exp_mem [MAX_LEN];
    logic [7:0] exp_len;
    logic       exp_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_data();
        logic [31:0] v;
        for (int i = 0; i < MAX_LEN; i++) v[8*i +: 8] = exp_mem[i];
        return v;
    endfunction

    // Frame-level reference: first min(n,MAX_LEN) bytes land, the rest are dropped and flag overflow.
    task automatic model_commit(input int n);
        int st;
        st = (n < MAX_LEN) ? n : MAX_LEN;
        for (int i = 0; i < st; i++) exp_mem[i] = fb[i];
        exp_len = 8'(st);
        exp_ovf = (n > MAX_LEN);
    endtask

    task automatic model_reset();
        for (int i = 0; i < MAX_LEN; i++) exp_mem[i] = 8'h00;
        exp_len = 8'h00;
        exp_ovf = 1'b0;
    endtask

    task automatic put_beat(input logic [7:0] d, input logic last);
        int cyc;
        cyc = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        forever begin
            @(negedge clk);
            chk("req_ready_excl", 32'(req & s_tready), 32'd0);
            chk("len_hold", 32'(app_data_len), 32'(exp_len));
            if (s_tready) break;
            cyc++;
            if (cyc > 300) begin
                total++;
                bad++;
                $display("FAIL accept_wait observed=no_accept expected=accept");
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            tick();
        end
        tick();
    endtask

    // Entered at the negedge of the rel/done cycle.
    task automatic check_commit(input logic exp_to);
        chk("done_pulse", 32'(done), 32'd1);
        chk("rel_pulse", 32'(rel), 32'd1);
        chk("req_in_rel", 32'(req), 32'd0);
        chk("len", 32'(app_data_len), 32'(exp_len));
        chk("data", app_data, exp_data());
        chk("overflow", 32'(overflow), 32'(exp_ovf));
        chk("timeout", 32'(timeout), 32'(exp_to));
        tick();
        @(negedge clk);
        chk("done_single", 32'(done), 32'd0);
        chk("rel_single", 32'(rel), 32'd0);
        chk("busy_drain", 32'(busy), 32'd1);
        chk("req_in_drain", 32'(req), 32'd0);
        tick();
        @(negedge clk);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("req_in_idle", 32'(req), 32'd0);
        tick();
    endtask

    task automatic send_frame(input int n, input int gap_max, input int drop_at, input int drop_len,
                              input bit hold_next, input logic [7:0] next_byte);
        for (int k = 0; k < n; k++) begin
            if (gap_max > 0 && k > 0) begin
                s_tvalid = 1'b0;
                repeat ($urandom_range(0, gap_max)) tick();
            end
            s_tvalid = 1'b1;
            s_tdata  = fb[k];
            s_tlast  = (k == n - 1);
            if (k == drop_at) begin
                ether_en = 1'b0;
                repeat (drop_len) begin
                    @(negedge clk);
                    chk("stall_ready", 32'(s_tready), 32'd0);
                    tick();
                end
                ether_en = 1'b1;
            end
            put_beat(fb[k], k == n - 1);
        end
        if (hold_next) begin
            s_tdata = next_byte;
            s_tlast = 1'b0;
        end else begin
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
        end
        model_commit(n);
        @(negedge clk);
        check_commit(1'b0);
    endtask

    initial begin
        int n;
        int c;
        model_reset();

        // Reset state
        #2;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_rel", 32'(rel), 32'd0);
        chk("rst_ready", 32'(s_tready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_to", 32'(timeout), 32'd0);
        chk("rst_len", 32'(app_data_len), 32'd0);
        chk("rst_data", app_data, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // 4-byte frame, exactly capacity
        fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44;
        send_frame(4, 0, -1, 0, 1'b0, 8'h00);
        chk("t2_word", app_data, 32'h4433_2211);
        chk("t2_len", 32'(app_data_len), 32'd4);

        // 6-byte frame overflows; a following 1-byte frame clears the flag
        for (int i = 0; i < 6; i++) fb[i] = 8'($urandom);
        send_frame(6, 1, -1, 0, 1'b0, 8'h00);
        chk("t3_ovf", 32'(overflow), 32'd1);
        fb[0] = 8'($urandom);
        send_frame(1, 0, -1, 0, 1'b0, 8'h00);
        chk("t3_len1", 32'(app_data_len), 32'd1);

        // Grant withheld 10 cycles, then dropped 3 cycles mid-frame
        gnt_delay = 10;
        for (int i = 0; i < 4; i++) fb[i] = 8'($urandom);
        send_frame(4, 0, 2, 3, 1'b0, 8'h00);
        gnt_delay = 0;

        // Back-to-back frames, valid never released between them
        for (int i = 0; i < 3; i++) fb[i] = 8'($urandom);
        for (int i = 0; i < 2; i++) nb[i] = 8'($urandom);
        send_frame(3, 0, -1, 0, 1'b1, nb[0]);
        for (int i = 0; i < 2; i++) fb[i] = nb[i];
        send_frame(2, 0, -1, 0, 1'b0, 8'h00);

        // Random frames with gaps, grant latency and grant drops
        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
            gnt_delay = $urandom_range(0, 3);
            send_frame(n, 2, ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1,
                       $urandom_range(1, 3), 1'b0, 8'h00);
        end
        gnt_delay = 0;

        // Asynchronous reset in the middle of a frame
        for (int i = 0; i < 4; i++) fb[i] = 8'($urandom);
        put_beat(fb[0], 1'b0);
        put_beat(fb[1], 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t1_req", 32'(req), 32'd0);
        chk("t1_rel", 32'(rel), 32'd0);
        chk("t1_ready", 32'(s_tready), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_len", 32'(app_data_len), 32'd0);
        chk("t1_data", app_data, 32'd0);
        model_reset();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Two bytes then an idle stall with grant held
        for (int i = 0; i < 3; i++) fb[i] = 8'($urandom);
        put_beat(fb[0], 1'b0);
        put_beat(fb[1], 1'b0);
        s_tvalid = 1'b0;
`ifdef ROS2_APP_DATA_LOADER_TIMEOUT_EN
        c = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rel) begin
                c = i;
                break;
            end
            tick();
        end
        // 8 idle cycles, committed on the edge closing the 8th, rel in the cycle after
        chk("t6_to_cycle", 32'(c), 32'd9);
        model_commit(2);
        check_commit(1'b1);
`else
        c = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t6_no_rel", 32'(rel), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("t6_still_busy", 32'(busy), 32'd1);
        chk("t6_no_to", 32'(timeout), 32'd0);
        chk("t6_len_hold", 32'(app_data_len), 32'(exp_len));
        tick();
        put_beat(fb[2], 1'b1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        model_commit(3);
        @(negedge clk);
        check_commit(1'b0);
`endif

        // A normal frame afterwards commits cleanly with both flags clear
        n = 3;
        for (int i = 0; i < n; i++) fb[i] = 8'($urandom);
        send_frame(n, 1, -1, 0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
